// File: rtl/ahb_lite_fir_master.sv
// AHB-Lite initiator for the memory-mapped FIR slave.
// Runs coefficient loads and sample/result round trips for a command port.
module ahb_lite_fir_master #(
    parameter int POLL_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_coeff,
    input  logic [63:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic        rsp_bus_err,
    output logic        rsp_timeout,
    output logic        hsel,
    output logic [3:0]  haddr,
    output logic        hsize,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [15:0] hwdata,
    input  logic [15:0] hrdata,
    input  logic        hresp
);
    localparam int CW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_COEF, S_WR_CONF, S_POLL_CONF,
        S_WR_SMP, S_POLL_STAT, S_RD_RES, S_RESP
    } state_t;

    state_t       state_q, state_d;
    logic         ph_q, ph_d;
    logic [1:0]   idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [63:0]  data_q, data_d;
    logic [15:0]  res_q, res_d;
    logic         err_q, err_d;
    logic         berr_q, berr_d;
    logic         to_q, to_d;
    logic         xfer, wr;
    logic [3:0]   addr;
    logic [15:0]  wd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            berr_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            res_q   <= res_d;
            err_q   <= err_d;
            berr_q  <= berr_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        res_d   = res_q;
        err_d   = err_q;
        berr_d  = berr_q;
        to_d    = to_q;
        cnt_inc = cnt_q + CW'(1);
        xfer    = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        wd      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    data_d  = cmd_data;
                    res_d   = '0;
                    err_d   = 1'b0;
                    berr_d  = 1'b0;
                    to_d    = 1'b0;
                    idx_d   = '0;
                    ph_d    = 1'b0;
                    state_d = cmd_coeff ? S_WR_COEF : S_WR_SMP;
                end
            end
            S_WR_COEF: begin
                xfer = 1'b1;
                wr   = 1'b1;
                addr = 4'h6 + {1'b0, idx_q, 1'b0};
                wd   = data_q[{idx_q, 4'b0000} +: 16];
            end
            S_WR_CONF: begin
                xfer = 1'b1;
                wr   = 1'b1;
                addr = 4'hE;
                wd   = 16'h0001;
            end
            S_POLL_CONF: begin
                xfer = 1'b1;
                addr = 4'hE;
            end
            S_WR_SMP: begin
                xfer = 1'b1;
                wr   = 1'b1;
                addr = 4'h4;
                wd   = data_q[15:0];
            end
            S_POLL_STAT: begin
                xfer = 1'b1;
                addr = 4'h0;
            end
            S_RD_RES: begin
                xfer = 1'b1;
                addr = 4'h2;
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (xfer) ph_d = ~ph_q;

        // Every transfer state resolves at the end of its data phase.
        if (xfer && ph_q) begin
            if (hresp) begin
                berr_d  = 1'b1;
                state_d = S_RESP;
            end else begin
                unique case (state_q)
                    S_WR_COEF: begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = S_WR_CONF;
                    end
                    S_WR_CONF: begin
                        cnt_d   = '0;
                        state_d = S_POLL_CONF;
                    end
                    S_POLL_CONF: begin
                        cnt_d = cnt_inc;
                        if (hrdata == 16'h0000) begin
                            state_d = S_RESP;
                        end else if (cnt_inc == CW'(POLL_LIMIT)) begin
                            to_d    = 1'b1;
                            state_d = S_RESP;
                        end
                    end
                    S_WR_SMP: begin
                        cnt_d   = '0;
                        state_d = S_POLL_STAT;
                    end
                    S_POLL_STAT: begin
                        cnt_d = cnt_inc;
                        if (!hrdata[0]) begin
                            err_d   = hrdata[8];
                            state_d = S_RD_RES;
                        end else if (cnt_inc == CW'(POLL_LIMIT)) begin
                            to_d    = 1'b1;
                            state_d = S_RESP;
                        end
                    end
                    S_RD_RES: begin
                        res_d   = hrdata;
                        state_d = S_RESP;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = '0;
        hwrite = 1'b0;
        hsize  = 1'b0;
        hwdata = '0;
        if (xfer && !ph_q) begin
            hsel   = 1'b1;
            htrans = 2'b10;
            haddr  = addr;
            hwrite = wr;
            hsize  = 1'b1;
        end
        if (xfer && ph_q && wr) hwdata = wd;
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_result  = res_q;
    assign rsp_err     = err_q;
    assign rsp_bus_err = berr_q;
    assign rsp_timeout = to_q;

endmodule

// File: tb/tb_ahb_lite_fir_master.sv
// Bench for ahb_lite_fir_master: scripted FIR slave model,
// bus-transfer and response scoreboards.
module tb_ahb_lite_fir_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_coeff = 1'b0;
    logic [63:0] cmd_data = '0;
    logic        rsp_valid;
    logic [15:0] rsp_result;
    logic        rsp_err, rsp_bus_err, rsp_timeout;
    logic        hsel, hsize, hwrite;
    logic [3:0]  haddr;
    logic [1:0]  htrans;
    logic [15:0] hwdata;
    logic [15:0] hrdata;
    logic        hresp;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        w;
        logic [3:0]  a;
        logic [15:0] d;
    } xfer_t;

    typedef struct packed {
        logic [15:0] res;
        logic        err;
        logic        berr;
        logic        to;
        int          lat;
    } rsp_t;

    xfer_t xq[$];
    rsp_t  rq[$];
    logic [15:0] exp_wd = '0;

    // slave model state
    logic        dp_valid = 1'b0;
    logic        dp_write = 1'b0;
    logic [3:0]  dp_addr = '0;
    int          stat_rd = 0;
    int          conf_rd = 0;
    int          busy_until = 0;
    int          conf_until = 0;
    logic [15:0] final_stat = '0;
    logic [15:0] result_val = '0;
    logic        err_en = 1'b0;
    logic [3:0]  err_addr = '0;

    ahb_lite_fir_master #(.POLL_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_coeff(cmd_coeff), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .rsp_bus_err(rsp_bus_err),
        .rsp_timeout(rsp_timeout),
        .hsel(hsel), .haddr(haddr), .hsize(hsize),
        .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata),
        .hrdata(hrdata), .hresp(hresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            dp_valid <= 1'b0;
        end else begin
            dp_valid <= hsel && (htrans == 2'b10);
            dp_addr  <= haddr;
            dp_write <= hwrite;
            if (dp_valid && !dp_write && dp_addr == 4'h0)
                stat_rd <= stat_rd + 1;
            if (dp_valid && !dp_write && dp_addr == 4'hE)
                conf_rd <= conf_rd + 1;
        end
    end

    always_comb begin
        hrdata = '0;
        hresp  = 1'b0;
        if (dp_valid) begin
            case (dp_addr)
                4'h0: hrdata = (stat_rd < busy_until) ? 16'h0001 : final_stat;
                4'h2: hrdata = result_val;
                4'hE: hrdata = (conf_rd < conf_until) ? 16'h0001 : 16'h0000;
                default: hrdata = '0;
            endcase
            hresp = err_en && (dp_addr == err_addr);
        end
    end

    // transfer monitor
    always @(negedge clk) begin
        if (!rst && hsel && htrans == 2'b10) begin
            chk("hsize", hsize, 1);
            chk("xfer_expected", xq.size() != 0, 1);
            if (xq.size() != 0) begin
                xfer_t x;
                x = xq.pop_front();
                chk("haddr", haddr, x.a);
                chk("hwrite", hwrite, x.w);
                exp_wd = x.d;
            end
        end
        if (!rst && dp_valid) begin
            chk("data_hsel", hsel, 0);
            if (dp_write) chk("hwdata", hwdata, exp_wd);
            else          chk("hwdata_rd", hwdata, 0);
        end
    end

    task automatic ex(input logic w, input logic [3:0] a,
                      input logic [15:0] d);
        xq.push_back('{w: w, a: a, d: d});
    endtask

    task automatic run_cmd(input logic coeff, input logic [63:0] data,
                           input rsp_t exp);
        int   n;
        bit   got;
        rsp_t e;
        rq.push_back(exp);
        @(negedge clk);
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_coeff = coeff;
        cmd_data  = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        n = 0;
        got = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1;
            else chk("ready_busy", cmd_ready, 0);
        end
        chk("rsp_seen", got, 1);
        if (got) begin
            e = rq.pop_front();
            chk("latency", n, e.lat);
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_bus_err", rsp_bus_err, e.berr);
            chk("rsp_timeout", rsp_timeout, e.to);
            @(negedge clk);
            chk("rsp_pulse", rsp_valid, 0);
            chk("ready_after", cmd_ready, 1);
            chk("rsp_hold", rsp_result, e.res);
        end
        chk("xfers_left", xq.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_hsel", hsel, 0);
        chk("rst_htrans", htrans, 0);
        chk("rst_hsize", hsize, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_flags", {rsp_result, rsp_err, rsp_bus_err, rsp_timeout}, 0);

        // coefficient load, confirm reads 0 first time
        conf_until = conf_rd;
        ex(1, 4'h6, 16'h0001); ex(1, 4'h8, 16'h0002);
        ex(1, 4'hA, 16'h0003); ex(1, 4'hC, 16'h0004);
        ex(1, 4'hE, 16'h0001); ex(0, 4'hE, 16'h0000);
        run_cmd(1, 64'h0004_0003_0002_0001,
                '{res: 16'h0, err: 0, berr: 0, to: 0, lat: 13});

        // sample, busy for three status reads
        busy_until = stat_rd + 3;
        final_stat = 16'h0000;
        result_val = 16'h00A0;
        ex(1, 4'h4, 16'h0010);
        for (int i = 0; i < 4; i++) ex(0, 4'h0, 16'h0);
        ex(0, 4'h2, 16'h0);
        run_cmd(0, 64'h0000_0000_0000_0010,
                '{res: 16'h00A0, err: 0, berr: 0, to: 0, lat: 13});

        // sample with overflow flag
        busy_until = stat_rd;
        final_stat = 16'h0100;
        result_val = 16'hFFFF;
        ex(1, 4'h4, 16'h0123);
        ex(0, 4'h0, 16'h0);
        ex(0, 4'h2, 16'h0);
        run_cmd(0, 64'h0000_0000_0000_0123,
                '{res: 16'hFFFF, err: 1, berr: 0, to: 0, lat: 7});

        // bus error on F2 write aborts the load
        err_en = 1'b1;
        err_addr = 4'hA;
        ex(1, 4'h6, 16'h0011); ex(1, 4'h8, 16'h0022);
        ex(1, 4'hA, 16'h0033);
        run_cmd(1, 64'h0044_0033_0022_0011,
                '{res: 16'h0, err: 0, berr: 1, to: 0, lat: 7});
        err_en = 1'b0;

        // status stuck busy
        busy_until = stat_rd + 1000;
        final_stat = 16'h0000;
        ex(1, 4'h4, 16'h0055);
        for (int i = 0; i < 4; i++) ex(0, 4'h0, 16'h0);
        run_cmd(0, 64'h0000_0000_0000_0055,
                '{res: 16'h0, err: 0, berr: 0, to: 1, lat: 11});
        busy_until = stat_rd;

        // reset in the sample write address phase
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_coeff = 1'b0;
        cmd_data  = 64'h77;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("pre_rst_hsel", hsel, 1);
        chk("pre_rst_haddr", haddr, 4'h4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_htrans", htrans, 0);
        chk("post_rst_hsel", hsel, 0);
        chk("post_rst_ready", cmd_ready, 1);

        // normal sample after reset
        busy_until = stat_rd + 1;
        final_stat = 16'h0000;
        result_val = 16'h1234;
        ex(1, 4'h4, 16'h0042);
        ex(0, 4'h0, 16'h0); ex(0, 4'h0, 16'h0);
        ex(0, 4'h2, 16'h0);
        run_cmd(0, 64'h0000_0000_0000_0042,
                '{res: 16'h1234, err: 0, berr: 0, to: 0, lat: 9});

        repeat (3) @(negedge clk);
        chk("idle_hsel", hsel, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_fir_master.md
Name: ahb_lite_fir_master

Overview:
AHB-Lite bus master that drives the memory-mapped FIR filter slave on behalf of a simple command port. A coefficient command writes F0..F3 and confirms the set, then polls until the loader has consumed it. A sample command writes one sample, polls status until the filter is idle, reads the result, and returns it with error flags. This block is the initiator end of the filter's AHB-Lite slave interface and is used as the on-chip driver and bench master.

Parameters:
POLL_LIMIT, 255, maximum status/confirm reads per poll loop before timeout.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  block idle, command accepted when cmd_valid & cmd_ready
cmd_coeff  in  1  1 = coefficient load, 0 = sample process
cmd_data  in  64  coeff: [15:0]=F0 .. [63:48]=F3; sample: [15:0]=sample
rsp_valid  out  1  one-cycle pulse, response fields valid
rsp_result  out  16  FIR result (sample cmd), 0 for coeff cmd
rsp_err  out  1  status bit 8 (filter overflow) from final status read
rsp_bus_err  out  1  hresp seen on any transfer of this command
rsp_timeout  out  1  poll loop hit POLL_LIMIT
hsel  out  1  slave select
haddr  out  4  byte address
hsize  out  1  always 1 (halfword) during address phase, 0 otherwise
htrans  out  2  2'b10 NONSEQ in address phase, 2'b00 IDLE otherwise
hwrite  out  1  write flag, address phase only
hwdata  out  16  write data, data phase only, 0 otherwise
hrdata  in  16  read data, sampled at end of data phase
hresp  in  1  slave error, sampled at end of data phase

Behaviour:
- Slave map: 0x0 status (bit0 busy, bit8 err); 0x2 result; 0x4 sample; 0x6/0x8/0xA/0xC F0..F3; 0xE coeff confirm (write 1, reads 0 once loaded). Slave has no wait states; busy is set from the cycle after a sample data phase until the result is valid.
- Reset: all outputs 0 except cmd_ready=1; FSM in IDLE; poll counter 0. Reset mid-transfer abandons it; bus outputs are idle on the following cycle.
- Transfers are non-overlapped, 2 cycles each: address phase (hsel=1, htrans=2'b10, haddr, hwrite, hsize=1), then data phase (hsel=0, htrans=0, hwdata driven if write, hrdata/hresp sampled at cycle end).
- Command accepted at edge T. First address phase occurs in cycle T+1. cmd_data is latched at acceptance, and cmd_ready=0 until the cycle after rsp_valid.
- States: IDLE -> (coeff) WR_COEF x4 (F0..F3, in order) -> WR_CONFIRM (write 0x0001 to 0xE) -> POLL_CONF (read 0xE until 0) -> RESP.
- States: IDLE -> (sample) WR_SAMPLE -> POLL_STAT (read 0x0 until bit0=0) -> RD_RESULT (read 0x2) -> RESP.
- Each state has an addr/data phase bit. A state advances after its data phase.
- Poll counter: cleared on poll-state entry, incremented per read. If a read still shows busy and the count equals POLL_LIMIT: set timeout, skip RD_RESULT, go to RESP with result 0.
- hresp=1 on any data phase: set bus_err, abort the remaining transfers, go to RESP. rsp_result=0 and rsp_err=0 unless already captured.
- rsp_err comes from bit 8 of the last status read that showed not-busy. For coefficient commands rsp_err=0.
- RESP lasts one cycle: rsp_valid=1 with all rsp_* fields. rsp_* hold their values until the next acceptance.
- Minimum latency with no polling retries: sample command = 3 transfers = 6 cycles, rsp_valid at T+7. Coefficient command = 6 transfers, rsp_valid at T+13.
- cmd_valid while busy is ignored, not queued.

Test Plan:
- Coeff cmd F0..F3 = 0x0001,0x0002,0x0003,0x0004, confirm reads 0 first time -> writes to 6,8,A,C,E with those data, then 0x0001; one read of 0xE; rsp_valid at T+13, all flags 0.
- Sample cmd 0x0010, slave status busy for 3 reads then 0x0000, result 0x00A0 -> four status reads, read 0x2, rsp_result=0x00A0, rsp_err=0.
- Sample cmd, final status 0x0100, result 0xFFFF -> rsp_err=1, rsp_result=0xFFFF.
- hresp=1 on F2 write -> no further transfers (no 0xC or 0xE); rsp_bus_err=1 next cycle after data phase; cmd_ready restored.
- Status stuck busy, POLL_LIMIT=4 -> exactly 4 status reads, no result read, rsp_timeout=1, rsp_result=0.
- rst asserted during WR_SAMPLE address phase -> next cycle htrans=0, hsel=0, cmd_ready=1; a new command then proceeds normally.
